seg_scan_arbiter: RTL and testbench

- Owns the 8-digit multiplexed 7-segment display and shares it between two requesters: the main-menu block and the game-mode block.
- Each requester presents a full 8-digit frame and a request line.
- The block arbitrates at frame boundaries, inserts a blanking slot on ownership change, and generates the digit scan (seg_com/seg_txt) from a prescaled tick.
- Sits between the mode blocks and the board display pins.

---
 rtl/seg_scan_arbiter_pkg.sv | 35 +++
 rtl/seg_scan_tick.sv | 33 +++
 rtl/seg_scan_arbiter.sv | 141 ++++++++++++++
 tb/tb_seg_scan_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_arbiter_pkg.sv
// Shared definitions for the 8-digit 7-segment scan arbiter.
// Holds the state encoding, the grant codes, the dark-display constants
// and two small helpers used by the arbiter top.
package seg_scan_arbiter_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  // State encoding; the values are shared with other display blocks.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MENU  = 2'd1;
  localparam logic [1:0] ST_GAME  = 2'd2;
  localparam logic [1:0] ST_BLANK = 2'd3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_MENU = 2'b01;
  localparam logic [1:0] GNT_GAME = 2'b10;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h00;
  localparam logic [NUM_DIGITS-1:0] COM_OFF   = 8'hFF;

  // Fixed priority: game over menu over nobody.
  function automatic logic [1:0] pick_owner(input logic req_menu,
                                            input logic req_game);
    if (req_game)      return ST_GAME;
    else if (req_menu) return ST_MENU;
    else               return ST_IDLE;
  endfunction

  // Active-low common line for digit sel; digit 0 is the leftmost (bit 7).
  function automatic logic [NUM_DIGITS-1:0] com_for(input logic [2:0] sel);
    return ~(8'h80 >> sel);
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler for multiplexed displays.
// Counts 0..SCAN_DIV-1 continuously and raises tick for the one clk in
// which the count sits at SCAN_DIV-1; the count then returns to 0.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset (count -> 0)
//   tick  - one-clk slot strobe
// CNT_W must be wide enough that 2^CNT_W >= SCAN_DIV.
module seg_scan_tick #(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 21
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Arbiter and scanner for the shared 8-digit multiplexed 7-segment display.
// Two requesters (menu, game) each present a full frame; ownership only
// changes at frame boundaries, and a one-slot blank separates two different
// owners so ghosting from the old frame never lands on the new one.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   req_menu, frame_menu - menu request and 56-bit frame (digit 0 in [55:49])
//   req_game, frame_game - game request and frame, same layout
//   seg_com              - active-low digit enables, digit i on bit 7-i
//   seg_txt              - segment pattern g..a for the enabled digit
//   grant                - 00 none, 01 menu, 10 game
//   frame_done           - one-clk pulse after an owned frame's last digit
// All outputs are registered from next-state values so a change made on a
// tick edge shows up on the pins in the cycle right after that edge.
module seg_scan_arbiter
  import seg_scan_arbiter_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 21
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_menu,
  input  logic [NUM_DIGITS*SEG_W-1:0] frame_menu,
  input  logic                        req_game,
  input  logic [NUM_DIGITS*SEG_W-1:0] frame_game,
  output logic [NUM_DIGITS-1:0]       seg_com,
  output logic [SEG_W-1:0]            seg_txt,
  output logic [1:0]                  grant,
  output logic                        frame_done
);

  logic tick;

  seg_scan_tick #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Element [7] holds bits [55:49], i.e. digit 0; digit i is element ~i.
  logic [NUM_DIGITS-1:0][SEG_W-1:0] menu_dig, game_dig;
  assign menu_dig = frame_menu;
  assign game_dig = frame_game;

  logic [1:0]            state_q, state_d;
  logic [1:0]            pending_q, pending_d;
  logic [2:0]            sel_q, sel_d;
  logic [NUM_DIGITS-1:0] seg_com_q, seg_com_d;
  logic [SEG_W-1:0]      seg_txt_q, seg_txt_d;
  logic [1:0]            grant_q, grant_d;
  logic                  frame_done_q, frame_done_d;
  logic [1:0]            want;

  assign want = pick_owner(req_menu, req_game);

  // Next state / digit index.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    if (tick) begin
      sel_d = sel_q + 3'd1;
      case (state_q)
        ST_IDLE: begin
          if (want != ST_IDLE) begin
            state_d = want;
            sel_d   = 3'd0;
          end
        end
        ST_MENU, ST_GAME: begin
          // Only the frame boundary may change ownership; sel wraps to 0.
          if (sel_q == 3'd7) begin
            frame_done_d = 1'b1;
            if (want == ST_IDLE) begin
              state_d = ST_IDLE;
            end else if (want != state_q) begin
              pending_d = want;
              state_d   = ST_BLANK;
            end
          end
        end
        default: begin
          // BLANK: hand over to the owner chosen at the boundary, no re-check.
          state_d = pending_q;
          sel_d   = 3'd0;
        end
      endcase
    end
  end

  // Output image for the next cycle; frames are read live, not latched.
  always_comb begin
    seg_com_d = COM_OFF;
    seg_txt_d = SEG_BLANK;
    grant_d   = GNT_NONE;
    case (state_d)
      ST_MENU: begin
        seg_com_d = com_for(sel_d);
        seg_txt_d = menu_dig[~sel_d];
        grant_d   = GNT_MENU;
      end
      ST_GAME: begin
        seg_com_d = com_for(sel_d);
        seg_txt_d = game_dig[~sel_d];
        grant_d   = GNT_GAME;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= ST_IDLE;
      sel_q        <= 3'd0;
      seg_com_q    <= COM_OFF;
      seg_txt_q    <= SEG_BLANK;
      grant_q      <= GNT_NONE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      seg_com_q    <= seg_com_d;
      seg_txt_q    <= seg_txt_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_com    = seg_com_q;
  assign seg_txt    = seg_txt_q;
  assign grant      = grant_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Self-checking bench for seg_scan_arbiter with SCAN_DIV=4.
// A slot-level reference model (who owns the display, which digit is shown,
// who is queued behind a blank) is advanced on every rising edge and checked
// against the pins on every falling edge; a slot table and a couple of hand
// sequences pin down the specific scenarios with literal expected values.
module tb_seg_scan_arbiter;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_menu, req_game;
  logic [55:0] frame_menu, frame_game;
  logic [7:0]  seg_com;
  logic [6:0]  seg_txt;
  logic [1:0]  grant;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_arbiter #(.SCAN_DIV(SD), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_menu   (req_menu),
    .frame_menu (frame_menu),
    .req_game   (req_game),
    .frame_game (frame_game),
    .seg_com    (seg_com),
    .seg_txt    (seg_txt),
    .grant      (grant),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: m_own 0 none, 1 menu, 2 game, 3 blank.
  int m_cnt = 0;
  int m_own = 0;
  int m_dig = 0;
  int m_nxt = 0;
  int m_done = 0;

  task automatic model_edge();
    int want;
    if (!rst_n) begin
      m_cnt = 0; m_own = 0; m_dig = 0; m_nxt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        want  = req_game ? 2 : (req_menu ? 1 : 0);
        if (m_own == 0) begin
          if (want != 0) begin m_own = want; m_dig = 0; end
        end else if (m_own == 3) begin
          m_own = m_nxt; m_dig = 0;
        end else if (m_dig < 7) begin
          m_dig = m_dig + 1;
        end else begin
          m_done = 1;
          m_dig  = 0;
          if (want == 0)           m_own = 0;
          else if (want != m_own) begin m_nxt = want; m_own = 3; end
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [6:0] digit_of(input logic [55:0] f, input int i);
    logic [55:0] s;
    s = f >> (49 - 7 * i);
    return s[6:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] one;
    logic [7:0] e_com;
    logic [6:0] e_txt;
    logic [1:0] e_gnt;
    one   = 8'd1;
    e_com = 8'hFF;
    e_txt = 7'h00;
    e_gnt = 2'b00;
    if (m_own == 1) begin
      e_com = ~(one << (7 - m_dig)); e_txt = digit_of(frame_menu, m_dig); e_gnt = 2'b01;
    end else if (m_own == 2) begin
      e_com = ~(one << (7 - m_dig)); e_txt = digit_of(frame_game, m_dig); e_gnt = 2'b10;
    end
    chk("model_seg_com", int'(seg_com), int'(e_com));
    chk("model_seg_txt", int'(seg_txt), int'(e_txt));
    chk("model_grant", int'(grant), int'(e_gnt));
    chk("model_frame_done", int'(frame_done), m_done);
  endtask

  // One clock: model advances with the inputs sampled on the edge, pins are
  // compared half a cycle later, callers change inputs after that.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       rm;
    logic       rg;
    logic [7:0] com;
    logic [6:0] txt;
    logic [1:0] gnt;
    logic       done;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [63:0] r64;

    // Each record: requests held for one slot, then the display expected
    // right after the tick edge closing that slot.
    tbl[0]  = '{1'b0, 1'b0, 8'hFF, 7'h00, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'hFF, 7'h00, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h7F, 7'h73, 2'b01, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'hBF, 7'h50, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'hDF, 7'h79, 2'b01, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'hEF, 7'h6D, 2'b01, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'hF7, 7'h6D, 2'b01, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'hFB, 7'h00, 2'b01, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'hFD, 7'h3F, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'hFE, 7'h06, 2'b01, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 7'h00, 2'b00, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'h7F, 7'h06, 2'b10, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'hBF, 7'h5B, 2'b10, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'hDF, 7'h4F, 2'b10, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'hEF, 7'h66, 2'b10, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'hF7, 7'h6D, 2'b10, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'hFB, 7'h7D, 2'b10, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'hFD, 7'h07, 2'b10, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'hFE, 7'h7F, 2'b10, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'hFF, 7'h00, 2'b00, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 8'h7F, 7'h06, 2'b10, 1'b0};

    rst_n      = 1'b0;
    req_menu   = 1'b0;
    req_game   = 1'b0;
    frame_menu = {7'h73, 7'h50, 7'h79, 7'h6D, 7'h6D, 7'h00, 7'h3F, 7'h06};
    frame_game = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};

    repeat (3) step();
    chk("reset_seg_com", int'(seg_com), 8'hFF);
    chk("reset_seg_txt", int'(seg_txt), 7'h00);
    chk("reset_grant", int'(grant), 2'b00);
    chk("reset_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    for (int r = 0; r < 21; r++) begin
      req_menu = tbl[r].rm;
      req_game = tbl[r].rg;
      repeat (SD) step();
      chk($sformatf("tbl%0d_seg_com", r), int'(seg_com), int'(tbl[r].com));
      chk($sformatf("tbl%0d_seg_txt", r), int'(seg_txt), int'(tbl[r].txt));
      chk($sformatf("tbl%0d_grant", r), int'(grant), int'(tbl[r].gnt));
      chk($sformatf("tbl%0d_frame_done", r), int'(frame_done), int'(tbl[r].done));
    end

    // Game owns from digit 0; switch to menu and stop in the blank slot.
    req_menu = 1'b1;
    req_game = 1'b0;
    for (int i = 0; i < 80 && m_own != 3; i++) step();
    chk("reach_blank", m_own, 3);
    chk("blank_seg_com", int'(seg_com), 8'hFF);
    chk("blank_grant", int'(grant), 2'b00);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // Prescaler restarts at 0: three dark clocks, tick on the fourth edge.
    repeat (SD - 1) step();
    chk("post_rst_dark", int'(seg_com), 8'hFF);
    chk("post_rst_grant_none", int'(grant), 2'b00);
    step();
    chk("post_rst_menu_com", int'(seg_com), 8'h7F);
    chk("post_rst_menu_grant", int'(grant), 2'b01);

    // Randomized traffic, checked against the model every clock.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) req_menu = ~req_menu;
      if ($urandom_range(0, 15) == 0) req_game = ~req_game;
      if ($urandom_range(0, 49) == 0) begin
        r64 = {$urandom, $urandom};
        frame_menu = r64[55:0];
      end
      if ($urandom_range(0, 49) == 0) begin
        r64 = {$urandom, $urandom};
        frame_game = r64[55:0];
      end
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
